keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad front end that produces the `valid_in`/`key_in` stream consumed by the door-lock controller. It scans a 4-row × 3-column keypad, debounces press and release, and emits each accepted key as a one-clock `valid_out` pulse with a 4-bit code on `key_out`. The `#` key emits code 10, the lock's enter code. The block sits between the keypad pins and the lock.

## Interface
Parameters:
- `SCAN_DIV`, default 16: clocks per column dwell; rows are sampled once per dwell.
- `DEBOUNCE`, default 4: consecutive identical samples required to accept a press or a release (≥1).

Ports:
- `clk` input 1: clock.
- `reset` input 1: reset, asynchronous, active-high.
- `row_in` input 4: keypad rows, active-low (pulled up externally), asynchronous to `clk`.
- `col_out` output 3: column drive, active-low one-hot.
- `valid_out` output 1: one-clock strobe, key accepted.
- `key_out` output 4: key code; holds last emitted value between strobes.

## Operation
- Layout and codes:
  - row0 = 1 2 3
  - row1 = 4 5 6
  - row2 = 7 8 9
  - row3 = `*`(11) 0 `#`(10)
  - Columns are 0/1/2 left to right.
- `row_in` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Divider `div_cnt` is free-running, 0..SCAN_DIV-1, and wraps. A "tick" is `div_cnt == SCAN_DIV-1`. Samples are taken only on ticks.
- States: SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
- SCAN:
  - On a tick with exactly one synchronized row low: latch {row, col}, set `stable_cnt`=1, go to DEBOUNCE. If DEBOUNCE==1, go straight to EMIT.
  - Otherwise, on a tick, advance the column 0→1→2→0.
  - Zero rows low, or two or more rows low, counts as no press.
- DEBOUNCE:
  - Column is held.
  - On a tick, if the same single row is low, increment `stable_cnt`. When it reaches DEBOUNCE, go to EMIT.
  - On any other sample, go to SCAN and advance the column.
- EMIT: lasts exactly one clock.
  - `valid_out`=1 and `key_out`=decoded code in the same cycle.
  - Then go to WAIT_RELEASE with `stable_cnt`=0.
- WAIT_RELEASE:
  - Column is held.
  - On a tick, if all rows are high, increment `stable_cnt`; otherwise clear it.
  - At DEBOUNCE, go to SCAN and advance the column.
  - A held key never produces a second strobe (no auto-repeat).
- `valid_out` is 1 only in EMIT.
- `key_out` changes only on entry to EMIT.

## Timing
- Reset values:
  - state SCAN
  - `col_out`=3'b110 (column 0 driven)
  - `valid_out`=0
  - `key_out`=4'd0
  - `div_cnt`=0, `stable_cnt`=0
- `col_out` is registered and changes only on ticks, so one full dwell of settling precedes each sample.
- Press latency:
  - A stable press reaches the synchronizer output 2 clocks after the pin changes.
  - Acceptance needs DEBOUNCE consecutive ticks on the key's column.
  - `valid_out` rises the clock after the accepting tick.
  - Worst-case press-to-strobe is (3 + DEBOUNCE)·SCAN_DIV + 3 clocks.
- Release completes DEBOUNCE ticks after the last low sample. The next key can be accepted no earlier than one dwell later.
- Counter widths are $clog2(SCAN_DIV) and $clog2(DEBOUNCE+1). No overflow is possible: counters saturate by state exit.
- Reset mid-operation in any state:
  - Immediate return to reset values.
  - Any in-progress debounce is discarded, and no strobe is emitted for it.
  - A key still held after reset deasserts must re-debounce from SCAN.
- Simultaneous keys in different columns: the first column scanned with a single low row wins. The other key is ignored until release.

## Structure
- Package `keypad_pkg` holds:
  - state encoding
  - KEY_ENTER=4'd10, KEY_STAR=4'd11
  - NUM_ROWS=4, NUM_COLS=3
- Sub-module `keypad_decode` is purely combinational: {row index, column index} → 4-bit code per the layout above.
- The synchronizer, divider, counters and FSM live in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3, with a keypad model that pulls row r low while `col_out[c]`==0 and key (r,c) is pressed.
- Reset asserted for 2 clocks, no keys pressed → `col_out`=110, `valid_out`=0, `key_out`=0; then columns cycle 110→101→011 every 4 clocks.
- Press `2` (row0, col1) held for 200 clocks, then release → exactly one `valid_out` pulse with `key_out`=2 and no further pulses; `key_out` stays 2 afterwards.
- Press `5` bouncing (low 6 clocks, high 4, repeated for 60 clocks), then released → no `valid_out`.
- Press and release 2, 4, 9, 0, `#` in turn, with scanner output wired to the door lock → strobes with codes 2, 4, 9, 0, 10; lock `door_open`=1 after the code-10 strobe.
- Press `1` and `4` together (same column, two rows low) → no strobe while both are held; releasing `4` → one strobe with `key_out`=1.
- Assert `reset` during DEBOUNCE of `8` (after 2 accepted samples), deassert with the key still held → no strobe before reset; exactly one strobe with code 8 occurring ≥3 ticks after reset deasserts.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and row helpers for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_EMIT         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_STAR  = 4'd11;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  // Exactly one row pulled low; zero or several low rows are not a press.
  function automatic logic single_low(input logic [NUM_ROWS-1:0] rows);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      n = n + {2'b00, ~rows[i]};
    end
    return (n == 3'd1);
  endfunction

  function automatic logic [1:0] low_index(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// rtl/keypad_decode.sv - combinational {row, column} to key code lookup
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [1:0] row_idx,
  input  logic [1:0] col_idx,
  output logic [3:0] code
);

  logic [3:0] row4;
  logic [3:0] col4;

  assign row4 = {2'b00, row_idx};
  assign col4 = {2'b00, col_idx};

  // Bottom row is * 0 #; the top three rows count 1..9 left to right.
  always_comb begin
    code = 4'd0;
    if (row_idx == 2'd3) begin
      case (col_idx)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        2'd2:    code = KEY_ENTER;
        default: code = 4'd0;
      endcase
    end else begin
      code = row4 * 4'd3 + col4 + 4'd1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad column scanner with press/release debounce
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic                valid_out,
  output logic [3:0]          key_out
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  state_t              state;
  state_t              next_state;
  logic [CNT_W-1:0]    stable_cnt;
  logic [CNT_W-1:0]    stable_nxt;
  logic [CNT_W-1:0]    stable_inc;
  logic [1:0]          col_idx;
  logic [1:0]          col_next;
  logic [1:0]          lat_row;
  logic [1:0]          lat_col;
  logic                latch_en;
  logic                advance;
  logic                single;
  logic [1:0]          sample_row;
  logic [1:0]          dec_row;
  logic [1:0]          dec_col;
  logic [3:0]          key_code;

  assign tick       = (div_cnt == DIV_LAST);
  assign single     = single_low(row_sync);
  assign sample_row = low_index(row_sync);
  assign stable_inc = stable_cnt + CNT_W'(1);
  assign col_next   = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;

  // When the press is accepted on its first sample the latch is still loading.
  assign dec_row = latch_en ? sample_row : lat_row;
  assign dec_col = latch_en ? col_idx : lat_col;

  keypad_decode u_decode (
    .row_idx (dec_row),
    .col_idx (dec_col),
    .code    (key_code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= '1;
      row_sync <= '1;
      div_cnt  <= '0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
      div_cnt  <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_SCAN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    stable_nxt = stable_cnt;
    latch_en   = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_SCAN: begin
        if (tick) begin
          if (single) begin
            latch_en   = 1'b1;
            stable_nxt = CNT_W'(1);
            next_state = (DEBOUNCE == 1) ? ST_EMIT : ST_DEBOUNCE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (tick) begin
          if (single && sample_row == lat_row) begin
            stable_nxt = stable_inc;
            if (stable_inc == CNT_DONE) next_state = ST_EMIT;
          end else begin
            next_state = ST_SCAN;
            advance    = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        stable_nxt = '0;
        next_state = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (tick) begin
          if (row_sync == '1) begin
            stable_nxt = stable_inc;
            if (stable_inc == CNT_DONE) begin
              next_state = ST_SCAN;
              advance    = 1'b1;
            end
          end else begin
            stable_nxt = '0;
          end
        end
      end
      default: next_state = ST_SCAN;
    endcase
  end

  always_comb begin
    valid_out = (state == ST_EMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      col_idx    <= 2'd0;
      col_out    <= 3'b110;
      lat_row    <= 2'd0;
      lat_col    <= 2'd0;
      key_out    <= 4'd0;
    end else begin
      stable_cnt <= stable_nxt;
      if (latch_en) begin
        lat_row <= sample_row;
        lat_col <= col_idx;
      end
      if (advance) begin
        col_idx <= col_next;
        col_out <= ~(3'b001 << col_next);
      end
      if (next_state == ST_EMIT && state != ST_EMIT) key_out <= key_code;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_in;
  logic [2:0]  col_out;
  logic        valid_out;
  logic [3:0]  key_out;
  logic [11:0] pressed = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobe_count = 0;
  int last_strobe_cyc = 0;
  logic [3:0] exp_q[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .valid_out (valid_out),
    .key_out   (key_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // A pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressed[r*3+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (valid_out) begin
      strobe_count++;
      last_strobe_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: got key %0d want no strobe", key_out);
      end else begin
        e = exp_q.pop_front();
        if (key_out !== e) begin
          bad++;
          $display("FAIL strobe_code: got %0d want %0d", key_out, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic press(input int r, input int c);
    pressed[r*3+c] = 1'b1;
  endtask

  task automatic release_key(input int r, input int c);
    pressed[r*3+c] = 1'b0;
  endtask

  task automatic wait_col_change(output logic ok);
    logic [2:0] prev;
    prev = col_out;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (col_out !== prev) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_col_value(input logic [2:0] want, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col_out === want) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic ok;
    int t_rel, t1, t2, t3;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (col_out !== 3'b110) begin bad++; $display("FAIL reset_col: got %b want 110", col_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    total++; if (key_out !== 4'd0) begin bad++; $display("FAIL reset_key: got %0d want 0", key_out); end
    reset = 1'b0;
    t_rel = cyc;
    wait_col_change(ok); t1 = cyc;
    total++; if (!ok || col_out !== 3'b101 || t1 - t_rel != 4) begin
      bad++; $display("FAIL col_step1: got %b after %0d want 101 after 4", col_out, t1 - t_rel);
    end
    wait_col_change(ok); t2 = cyc;
    total++; if (!ok || col_out !== 3'b011 || t2 - t1 != 4) begin
      bad++; $display("FAIL col_step2: got %b after %0d want 011 after 4", col_out, t2 - t1);
    end
    wait_col_change(ok); t3 = cyc;
    total++; if (!ok || col_out !== 3'b110 || t3 - t2 != 4) begin
      bad++; $display("FAIL col_step3: got %b after %0d want 110 after 4", col_out, t3 - t2);
    end
  endtask

  task automatic test_single_key();
    int n0, t0;
    n0 = strobe_count;
    exp_q.push_back(4'd2);
    press(0, 1);
    t0 = cyc;
    repeat (200) @(negedge clk);
    total++; if (strobe_count - n0 != 1) begin
      bad++; $display("FAIL single_count_held: got %0d want 1", strobe_count - n0);
    end
    total++; if (strobe_count - n0 == 1 && (last_strobe_cyc - t0 > 27 || last_strobe_cyc < t0)) begin
      bad++; $display("FAIL single_latency: got %0d want <=27", last_strobe_cyc - t0);
    end
    release_key(0, 1);
    repeat (60) @(negedge clk);
    total++; if (strobe_count - n0 != 1) begin
      bad++; $display("FAIL single_count_after: got %0d want 1", strobe_count - n0);
    end
    total++; if (key_out !== 4'd2) begin bad++; $display("FAIL single_key_hold: got %0d want 2", key_out); end
  endtask

  task automatic test_bounce();
    int n0;
    n0 = strobe_count;
    for (int i = 0; i < 6; i++) begin
      press(1, 1);
      repeat (6) @(negedge clk);
      release_key(1, 1);
      repeat (4) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    total++; if (strobe_count != n0) begin
      bad++; $display("FAIL bounce_count: got %0d want 0", strobe_count - n0);
    end
  endtask

  task automatic test_sequence();
    int rows[5] = '{0, 1, 2, 3, 3};
    int cols[5] = '{1, 0, 2, 1, 2};
    logic [3:0] codes[5] = '{4'd2, 4'd4, 4'd9, 4'd0, 4'd10};
    int n0;
    n0 = strobe_count;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(codes[i]);
      press(rows[i], cols[i]);
      repeat (40) @(negedge clk);
      release_key(rows[i], cols[i]);
      repeat (40) @(negedge clk);
    end
    total++; if (strobe_count - n0 != 5) begin
      bad++; $display("FAIL seq_count: got %0d want 5", strobe_count - n0);
    end
    total++; if (key_out !== 4'd10) begin bad++; $display("FAIL seq_last_key: got %0d want 10", key_out); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL seq_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_two_keys();
    int n0;
    n0 = strobe_count;
    press(0, 0);
    press(1, 0);
    repeat (100) @(negedge clk);
    total++; if (strobe_count != n0) begin
      bad++; $display("FAIL two_keys_held: got %0d want 0", strobe_count - n0);
    end
    exp_q.push_back(4'd1);
    release_key(1, 0);
    repeat (60) @(negedge clk);
    release_key(0, 0);
    repeat (40) @(negedge clk);
    total++; if (strobe_count - n0 != 1) begin
      bad++; $display("FAIL two_keys_count: got %0d want 1", strobe_count - n0);
    end
    total++; if (key_out !== 4'd1) begin bad++; $display("FAIL two_keys_key: got %0d want 1", key_out); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    int n0, r_cyc;
    wait_col_value(3'b110, ok);
    press(2, 1);
    if (ok) wait_col_value(3'b101, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_col_timeout: got none want 101"); end
    repeat (9) @(negedge clk);
    n0 = strobe_count;
    reset = 1'b1;
    #1;
    total++; if (col_out !== 3'b110 || valid_out !== 1'b0 || key_out !== 4'd0) begin
      bad++; $display("FAIL mid_async_reset: got col=%b valid=%b key=%0d want 110 0 0", col_out, valid_out, key_out);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    r_cyc = cyc;
    total++; if (strobe_count != n0) begin
      bad++; $display("FAIL mid_pre_reset_strobe: got %0d want 0", strobe_count - n0);
    end
    exp_q.push_back(4'd8);
    for (int i = 0; i < 60 && strobe_count == n0; i++) @(negedge clk);
    total++; if (strobe_count - n0 != 1) begin
      bad++; $display("FAIL mid_strobe_count: got %0d want 1", strobe_count - n0);
    end else if (last_strobe_cyc - r_cyc < 12) begin
      bad++; $display("FAIL mid_strobe_delay: got %0d want >=12", last_strobe_cyc - r_cyc);
    end
    release_key(2, 1);
    repeat (40) @(negedge clk);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_pending: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_sequence();
    test_two_keys();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
